// File: rtl/ycr_rst_seq_pkg.sv
// ycr_rst_seq_pkg: shared FSM state type and counter sizing helper
// for the ycr_reset_seq_ctrl reset sequencer.
package ycr_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    // Counter must hold both MIN_ASSERT-1 and any release delay value
    function automatic int unsigned cnt_width(
        input int unsigned dly_w,
        input int unsigned min_assert
    );
        int unsigned w_hold;
        w_hold = $clog2(min_assert);
        return (dly_w > w_hold) ? dly_w : w_hold;
    endfunction

endpackage

// File: rtl/ycr_rst_seq_sync.sv
// ycr_rst_seq_sync: single-bit multi-stage synchroniser for one
// asynchronous reset request line; resets to 0 (request asserted).
module ycr_rst_seq_sync
    import ycr_rst_seq_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    // Shift the raw request through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= '0;
        end else begin
            r_ff[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_ff[s] <= r_ff[s-1];
            end
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/ycr_reset_seq_ctrl.sv
// ycr_reset_seq_ctrl: holds and releases NUM_CH reset domains in order.
// Macro YCR_RST_SEQ_SWREQ_EN enables the sw_rst_req request path.
module ycr_reset_seq_ctrl
    import ycr_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_ASSERT  = 4,
    parameter int unsigned DLY_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    test_mode,
    input  logic                    test_rst_n,
    input  logic [NUM_CH-1:0]       rst_req_n_in,
    input  logic [NUM_CH-1:0]       sw_rst_req,
    input  logic [NUM_CH*DLY_W-1:0] rel_dly,
    output logic [NUM_CH-1:0]       rst_n_out,
    output logic [NUM_CH-1:0]       rst_n_status,
    output logic                    seq_busy
);

    localparam int unsigned CNT_W = cnt_width(DLY_W, MIN_ASSERT);
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MIN_ASSERT - 1);

    logic              w_rst_n;
    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_sw;
    logic [NUM_CH-1:0] w_req;
    logic              w_any;
    logic [PTR_W-1:0]  w_low;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [DLY_W-1:0]  w_dly [NUM_CH];

    seq_state_e        r_state;
    seq_state_e        w_state_d;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [NUM_CH-1:0] r_rel;
    logic [NUM_CH-1:0] w_rel_d;

    assign w_rst_n = test_mode ? test_rst_n : rst_n;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_dly[gi] = rel_dly[gi*DLY_W +: DLY_W];

        ycr_rst_seq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (w_rst_n),
            .i_d   (rst_req_n_in[gi]),
            .o_q   (w_sync[gi])
        );
    end

`ifdef YCR_RST_SEQ_SWREQ_EN
    assign w_sw = sw_rst_req;
`else
    logic w_sw_unused;
    assign w_sw_unused = ^sw_rst_req;
    assign w_sw = '0;
`endif

    assign w_req = ~w_sync | w_sw;
    assign w_any = |w_req;
    assign w_ptr_nxt = (r_ptr == LAST_CH) ? r_ptr : r_ptr + 1'b1;

    // Lowest requested channel index wins
    always_comb begin
        w_low = LAST_CH;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_low = PTR_W'(k);
            end
        end
    end

    // Next-state: re-assert on new low-index requests, else hold/release
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_rel_d   = r_rel;
        if (w_any && (r_state == ST_RUN || w_low < r_ptr)) begin
            w_state_d = ST_HOLD;
            w_ptr_d   = w_low;
            w_cnt_d   = HOLD_LD;
            for (int k = 0; k < NUM_CH; k++) begin
                if (PTR_W'(k) >= w_low) begin
                    w_rel_d[k] = 1'b0;
                end
            end
        end else begin
            unique case (r_state)
                ST_HOLD: begin
                    if (w_any) begin
                        w_cnt_d = HOLD_LD;
                    end else if (r_cnt == '0) begin
                        w_state_d = ST_RELEASE;
                        w_cnt_d   = CNT_W'(w_dly[r_ptr]);
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - 1'b1;
                    end else if (!w_req[r_ptr]) begin
                        w_rel_d[r_ptr] = 1'b1;
                        if (r_ptr == LAST_CH) begin
                            w_state_d = ST_RUN;
                        end else begin
                            w_ptr_d = w_ptr_nxt;
                            w_cnt_d = CNT_W'(w_dly[w_ptr_nxt]);
                        end
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    w_state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Sequencer state, pointer, counter and release flops
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_HOLD;
            r_ptr   <= '0;
            r_cnt   <= HOLD_LD;
            r_rel   <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
            r_rel   <= w_rel_d;
        end
    end

    assign rst_n_out    = test_mode ? {NUM_CH{test_rst_n}} : r_rel;
    assign rst_n_status = r_rel;
    assign seq_busy     = (r_state != ST_RUN);

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
// tb_ycr_reset_seq_ctrl: scoreboard bench for ycr_reset_seq_ctrl with
// a timestamp-based reference model of the release rules.
module tb_ycr_reset_seq_ctrl;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_ASSERT  = 4;
    localparam int DLY_W       = 4;

    typedef logic [NUM_CH*DLY_W-1:0] dly_vec_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;

`ifdef YCR_RST_SEQ_SWREQ_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst_n = 1'b1;
    logic     test_mode = 1'b0;
    logic     test_rst_n = 1'b1;
    ch_vec_t  rst_req_n_in = '1;
    ch_vec_t  sw_rst_req = '0;
    dly_vec_t rel_dly = 16'h1203;
    ch_vec_t  rst_n_out;
    ch_vec_t  rst_n_status;
    logic     seq_busy;

    ycr_reset_seq_ctrl #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_ASSERT  (MIN_ASSERT),
        .DLY_W       (DLY_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_mode    (test_mode),
        .test_rst_n   (test_rst_n),
        .rst_req_n_in (rst_req_n_in),
        .sw_rst_req   (sw_rst_req),
        .rel_dly      (rel_dly),
        .rst_n_out    (rst_n_out),
        .rst_n_status (rst_n_status),
        .seq_busy     (seq_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(input string nm,
                                  input logic [31:0] got,
                                  input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t",
                      nm, got, exp, $time);
    endfunction

    function automatic void chk_out(input string nm,
                                    input ch_vec_t exp_out,
                                    input logic exp_busy);
        check({nm, "_out"}, 32'(rst_n_out), 32'(exp_out));
        check({nm, "_busy"}, 32'(seq_busy), 32'(exp_busy));
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        ch_vec_t out;
        ch_vec_t st;
        logic    busy;
    } exp_t;

    exp_t    sb_q[$];
    ch_vec_t m_hist[$];
    int      m_mode;   // 0 hold, 1 releasing, 2 all released
    int      m_ptr;
    int      m_last;   // edge of most recent request seen while holding
    int      m_tgt;    // edge at which current channel was targeted
    int      m_dly;
    int      n_edge = 0;
    ch_vec_t m_rel;

    function automatic int field(input int k);
        return int'((rel_dly >> (k * DLY_W)) & dly_vec_t'((1 << DLY_W) - 1));
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_ptr  = 0;
        m_rel  = '0;
        m_last = n_edge;
        m_hist.delete();
        for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back('0);
    endfunction

    function automatic void model_step();
        ch_vec_t req;
        int      low;
        req = ~m_hist[0];
        if (SW_EN) req = req | sw_rst_req;
        void'(m_hist.pop_front());
        m_hist.push_back(rst_req_n_in);
        low = NUM_CH;
        for (int k = NUM_CH - 1; k >= 0; k--) if (req[k]) low = k;
        n_edge++;
        if (req != '0 && (m_mode == 2 || low < m_ptr)) begin
            m_mode = 0;
            m_ptr  = low;
            m_last = n_edge;
            for (int k = low; k < NUM_CH; k++) m_rel[k] = 1'b0;
        end else if (m_mode == 0) begin
            if (req != '0) m_last = n_edge;
            else if (n_edge - m_last >= MIN_ASSERT) begin
                m_mode = 1;
                m_tgt  = n_edge;
                m_dly  = field(m_ptr);
            end
        end else if (m_mode == 1) begin
            if (n_edge >= m_tgt + m_dly + 1 && !req[m_ptr]) begin
                m_rel[m_ptr] = 1'b1;
                if (m_ptr == NUM_CH - 1) m_mode = 2;
                else begin
                    m_ptr++;
                    m_tgt = n_edge;
                    m_dly = field(m_ptr);
                end
            end
        end
    endfunction

    // One clock: advance the model, queue its expectation, land mid-cycle
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_step();
        e.out  = test_mode ? {NUM_CH{test_rst_n}} : m_rel;
        e.st   = m_rel;
        e.busy = (m_mode != 2);
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs with queued expectations
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_out", 32'(rst_n_out), 32'(e.out));
            check("sb_status", 32'(rst_n_status), 32'(e.st));
            check("sb_busy", 32'(seq_busy), 32'(e.busy));
        end
    end

    // ---------------- directed sequences ----------------
    // mode 0: plain power-on; 1: abort mid-release; 2: ch1 held low
    task automatic power_on(input int mode);
        int last_e;
        rst_n = 1'b0;
        rst_req_n_in = '1;
        sw_rst_req = '0;
        #1;
        model_reset();
        check("rst_out", 32'(rst_n_out), 32'h0);
        check("rst_status", 32'(rst_n_status), 32'h0);
        check("rst_busy", 32'(seq_busy), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        last_e = (mode == 0) ? 16 : (mode == 1) ? 8 : 34;
        for (int e = 1; e <= last_e; e++) begin
            if (mode == 2) rst_req_n_in[1] = !(e >= 7 && e <= 26);
            step();
            if (mode == 0) begin
                case (e)
                    9:  chk_out("po_t7", 4'b0000, 1'b1);
                    10: chk_out("po_t8", 4'b0001, 1'b1);
                    11: chk_out("po_t9", 4'b0011, 1'b1);
                    13: chk_out("po_t11", 4'b0011, 1'b1);
                    14: chk_out("po_t12", 4'b0111, 1'b1);
                    15: chk_out("po_t13", 4'b0111, 1'b1);
                    16: chk_out("po_t14", 4'b1111, 1'b0);
                    default: ;
                endcase
            end else if (mode == 2) begin
                case (e)
                    10: chk_out("st_t8", 4'b0001, 1'b1);
                    28: chk_out("st_t26", 4'b0001, 1'b1);
                    29: chk_out("st_t27", 4'b0011, 1'b1);
                    31: chk_out("st_t29", 4'b0011, 1'b1);
                    32: chk_out("st_t30", 4'b0111, 1'b1);
                    34: chk_out("st_t32", 4'b1111, 1'b0);
                    default: ;
                endcase
            end
        end
        if (mode == 1) begin
            chk_out("abort_pre", 4'b0000, 1'b1);
            rst_n = 1'b0;
            #1;
            check("abort_out", 32'(rst_n_out), 32'h0);
            check("abort_status", 32'(rst_n_status), 32'h0);
            check("abort_busy", 32'(seq_busy), 32'h1);
        end
    endtask

    task automatic pulse_ch2();
        rst_req_n_in[2] = 1'b0;
        step();
        rst_req_n_in[2] = 1'b1;
        step();
        chk_out("p2_e1", 4'b1111, 1'b0);
        step();
        chk_out("p2_e", 4'b0011, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step();
            case (i)
                6: chk_out("p2_e6", 4'b0011, 1'b1);
                7: chk_out("p2_e7", 4'b0111, 1'b1);
                8: chk_out("p2_e8", 4'b0111, 1'b1);
                9: chk_out("p2_e9", 4'b1111, 1'b0);
                default: ;
            endcase
        end
    endtask

    task automatic sw_pulse();
        sw_rst_req = 4'b0100;
        step();
        sw_rst_req = '0;
`ifdef YCR_RST_SEQ_SWREQ_EN
        chk_out("sw_hit", 4'b0011, 1'b1);
`else
        chk_out("sw_ignored", 4'b1111, 1'b0);
`endif
        repeat (10) step();
        chk_out("sw_after", 4'b1111, 1'b0);
    endtask

    task automatic test_mode_seq();
        test_mode = 1'b1;
        #1;
        check("tm_out_hi", 32'(rst_n_out), 32'hf);
        step();
        step();
        test_rst_n = 1'b0;
        #1;
        model_reset();
        check("tm_out_lo", 32'(rst_n_out), 32'h0);
        check("tm_status_rst", 32'(rst_n_status), 32'h0);
        check("tm_busy_rst", 32'(seq_busy), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        test_rst_n = 1'b1;
        #1;
        check("tm_out_bypass", 32'(rst_n_out), 32'hf);
        check("tm_status_held", 32'(rst_n_status), 32'h0);
        repeat (16) step();
        check("tm_status_run", 32'(rst_n_status), 32'hf);
        rst_n = 1'b0;
        #1;
        check("tm_rst_n_masked", 32'(rst_n_status), 32'hf);
        rst_n = 1'b1;
        test_mode = 1'b0;
        #1;
        check("tm_exit_out", 32'(rst_n_out), 32'hf);
    endtask

    task automatic random_run(input int cycles);
        int low_left[NUM_CH];
        for (int k = 0; k < NUM_CH; k++) low_left[k] = 0;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (low_left[k] > 0) low_left[k]--;
                else if ($urandom_range(0, 99) == 0)
                    low_left[k] = $urandom_range(1, 12);
                rst_req_n_in[k] = (low_left[k] == 0);
            end
            sw_rst_req = '0;
            if ($urandom_range(0, 49) == 0)
                sw_rst_req = ch_vec_t'(1 << $urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 199) == 0)
                rel_dly = dly_vec_t'($urandom);
            step();
        end
        rst_req_n_in = '1;
        sw_rst_req = '0;
        rel_dly = 16'h1203;
        repeat (80) step();
        chk_out("rand_settle", 4'b1111, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        power_on(0);
        repeat (2) step();
        pulse_ch2();
        sw_pulse();
        test_mode_seq();
        repeat (2) step();
        random_run(800);
        power_on(1);
        power_on(0);
        power_on(2);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
